muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 44 ++++
 rtl/muldiv_divstep.sv | 22 ++
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state encoding, default geometry and op classification helpers.
package muldiv_pkg;

  localparam int W_DEF     = 32;
  localparam int MUL_K_DEF = 4;

  // Bit 0 set marks the unsigned variant of each op pair.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MADDU = 3'd3,
    OP_MSUB  = 3'd4,
    OP_MSUBU = 3'd5,
    OP_DIV   = 3'd6,
    OP_DIVU  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic is_div_op(input logic [2:0] op);
    return op[2:1] == 2'b11;
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_madd_op(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction

  function automatic logic is_msub_op(input logic [2:0] op);
    return op[2:1] == 2'b10;
  endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it does not borrow.
module muldiv_divstep #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_n,
  output logic [W-1:0] quo_n
);

  logic [W:0] shifted;
  logic [W:0] diff;

  assign shifted = {rem, quo[W-1]};
  assign diff    = shifted - {1'b0, dvs};
  // A borrow out of the top bit means the divisor did not fit.
  assign rem_n   = diff[W] ? shifted[W-1:0] : diff[W-1:0];
  assign quo_n   = {quo[W-2:0], ~diff[W]};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply / multiply-accumulate / divide unit with {HI,LO} result.
// Signed ops run on magnitudes; the sign is restored in a single FIX cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int MUL_K = MUL_K_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           cancel_i,
  input  logic [2:0]     op_i,
  input  logic [W-1:0]   opa_i,
  input  logic [W-1:0]   opb_i,
  input  logic [2*W-1:0] acc_i,
  output logic           busy_o,
  output logic           ready_o,
  output logic [2*W-1:0] result_o,
  output logic           div_by_zero_o
);

  localparam int CNT_W = $clog2(W) + 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(W / MUL_K);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic n);
    return n ? (~v + W'(1)) : v;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic n);
    return n ? (~v + (2*W)'(1)) : v;
  endfunction

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [2*W-1:0]   acc_q;
  logic [2*W-1:0]   prod;
  logic [2*W-1:0]   mcand;
  logic [W-1:0]     mplier;
  logic             neg_q, neg_r, dbz_q;
  logic [2*W-1:0]   result_q;

  logic signed [W-1:0] opa_s, opb_s;
  logic             sgn_op, accept, div_req, dbz_req;
  logic [W-1:0]     mag_a, mag_b;
  logic [2*W-1:0]   pp_sum;
  logic [W-1:0]     rem_n, quo_n;
  logic [2*W-1:0]   prod_f, fix_res;
  logic [W-1:0]     quo_f, rem_f;

  assign opa_s   = opa_i;
  assign opb_s   = opb_i;
  assign sgn_op  = is_signed_op(op_i);
  assign accept  = (state == ST_IDLE || state == ST_DONE) && start_i && !cancel_i;
  assign div_req = is_div_op(op_i);
  assign dbz_req = div_req && (opb_i == '0);
  assign mag_a   = neg_w(opa_i, sgn_op && (opa_s < 0));
  assign mag_b   = neg_w(opb_i, sgn_op && (opb_s < 0));

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (accept)
          state_nxt = dbz_req ? ST_DONE : (div_req ? ST_DIV : ST_MUL);
        else
          state_nxt = ST_IDLE;
      end
      ST_MUL, ST_DIV: begin
        if (cancel_i)
          state_nxt = ST_IDLE;
        else if (cnt == CNT_ONE)
          state_nxt = ST_FIX;
      end
      ST_FIX:  state_nxt = cancel_i ? ST_IDLE : ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // MUL_K partial products per cycle against the left-shifting multiplicand.
  always_comb begin
    pp_sum = '0;
    for (int j = 0; j < MUL_K; j++)
      if (mplier[j])
        pp_sum = pp_sum + (mcand << j);
  end

  // During division prod holds {remainder, dividend/quotient}; mplier holds the divisor.
  muldiv_divstep #(.W(W)) u_divstep (
    .rem   (prod[2*W-1:W]),
    .quo   (prod[W-1:0]),
    .dvs   (mplier),
    .rem_n (rem_n),
    .quo_n (quo_n)
  );

  always_comb begin
    prod_f = neg_2w(prod, neg_q);
    quo_f  = neg_w(prod[W-1:0], neg_q);
    rem_f  = neg_w(prod[2*W-1:W], neg_r);
    if (is_div_op(op_q))
      fix_res = {rem_f, quo_f};
    else if (is_madd_op(op_q))
      fix_res = acc_q + prod_f;
    else if (is_msub_op(op_q))
      fix_res = acc_q - prod_f;
    else
      fix_res = prod_f;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      prod     <= '0;
      mcand    <= '0;
      mplier   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      op_q   <= op_i;
      acc_q  <= acc_i;
      mplier <= mag_b;
      neg_q  <= sgn_op && (opa_i[W-1] ^ opb_i[W-1]);
      neg_r  <= sgn_op && opa_i[W-1];
      dbz_q  <= dbz_req;
      if (dbz_req)
        result_q <= {opa_i, {W{1'b1}}};
      if (div_req) begin
        prod <= {{W{1'b0}}, mag_a};
        cnt  <= DIV_CNT;
      end else begin
        prod  <= '0;
        mcand <= {{W{1'b0}}, mag_a};
        cnt   <= MUL_CNT;
      end
    end else if (!cancel_i) begin
      unique case (state)
        ST_MUL: begin
          prod   <= prod + pp_sum;
          mcand  <= mcand << MUL_K;
          mplier <= mplier >> MUL_K;
          cnt    <= cnt - CNT_ONE;
        end
        ST_DIV: begin
          prod <= {rem_n, quo_n};
          cnt  <= cnt - CNT_ONE;
        end
        ST_FIX:  result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign busy_o        = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
  assign ready_o       = (state == ST_DONE);
  assign div_by_zero_o = (state == ST_DONE) && dbz_q;
  assign result_o      = result_q;

endmodule
